eth_payload_extractor: RTL

ETH_PAYLOAD_EXTRACTOR -- requirements
Module: eth_payload_extractor

---
 rtl/eth_pkg.sv | 28 ++
 rtl/eth_payload_extractor_if.sv | 8 +
 rtl/fcs_strip_delay.sv | 39 +++
 rtl/eth_payload_extractor.sv | 139 +++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII payload extractor.
// Optional build macro MAC_FILTER_EN enables destination-MAC filtering.
package eth_pkg;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      PREAMBLE,
      HEADER,
      PAYLOAD,
      DROP
   } eth_state_t;

   localparam logic [5:0] HEADER_DIBITS  = 6'd56;
   localparam logic [5:0] MAC_DIBITS     = 6'd24;
   localparam logic [4:0] FCS_DIBITS     = 5'd16;
   localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0] SFD_DIBIT      = 2'b11;

   // Dibit k of a MAC as it appears on the wire: bytes MSB-first, dibits LSB-first.
   function automatic logic [1:0] mac_dibit(input logic [47:0] mac, input logic [5:0] k);
      logic [47:0] sh;
      sh = mac >> {3'd5 - k[4:2], 3'b000};
      sh = sh >> {k[1:0], 1'b0};
      return sh[1:0];
   endfunction

endpackage

// File: rtl/eth_payload_extractor_if.sv
// Dibit stream bundle: a valid strobe and one 2-bit data word.
interface eth_payload_extractor_if;
   logic       valid;
   logic [1:0] data;

   modport master (output valid, data);
   modport slave  (input  valid, data);
endinterface

// File: rtl/fcs_strip_delay.sv
// 16-dibit delay line: emits a dibit only once 16 newer ones exist,
// so the trailing FCS never leaves. flush discards the contents.
module fcs_strip_delay
   import eth_pkg::*;
(
   input  logic                      eth_refclk,
   input  logic                      rst,
   input  logic                      flush,
   eth_payload_extractor_if.slave    din,
   eth_payload_extractor_if.master   dout
);

   localparam int LINE_W = 2 * int'(FCS_DIBITS);

   logic [LINE_W-1:0] line_q;
   logic [4:0]        fill_q;
   logic              full;

   assign full = (fill_q == FCS_DIBITS);

   always_ff @(posedge eth_refclk) begin
      // NOTE: the data line is cleared along with fill_q even though fill_q alone
      // gates reads, so no dibit of an aborted frame survives a reset or flush.
      if (rst || flush) begin
         line_q     <= '0;
         fill_q     <= '0;
         dout.valid <= 1'b0;
         dout.data  <= 2'b00;
      end else begin
         dout.valid <= din.valid && full;
         dout.data  <= (din.valid && full) ? line_q[LINE_W-1 -: 2] : 2'b00;
         if (din.valid) begin
            line_q <= {line_q[LINE_W-3:0], din.data};
            if (!full) fill_q <= fill_q + 5'd1;
         end
      end
   end

endmodule

// File: rtl/eth_payload_extractor.sv
// RMII frame receiver: strips preamble/SFD/header/FCS and forwards payload dibits.
// Define MAC_FILTER_EN to drop frames not addressed to MY_MAC or broadcast.
module eth_payload_extractor
   import eth_pkg::*;
#(
   parameter logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91
) (
   input  logic       eth_refclk,
   input  logic       rst,
   input  logic       crsdv,
   input  logic [1:0] rxd,
   output logic       axiov,
   output logic [1:0] axiod,
   output logic       frame_done,
   output logic       frame_dropped
);

   if (MY_MAC == 48'h0) begin : g_mac_guard
      $error("MY_MAC must be a non-zero station address");
   end

   eth_state_t state_q, state_d;
   logic [5:0] hdr_cnt_q, hdr_cnt_d;
   logic       done_d, dropped_d, push, flush;
`ifdef MAC_FILTER_EN
   logic       ucast_miss_q, ucast_miss_d, bcast_miss_q, bcast_miss_d;
`endif

   eth_payload_extractor_if push_if ();
   eth_payload_extractor_if out_if ();

   assign push_if.valid = push;
   assign push_if.data  = rxd;
   assign axiov         = out_if.valid;
   assign axiod         = out_if.data;

   fcs_strip_delay u_delay (
      .eth_refclk (eth_refclk),
      .rst        (rst),
      .flush      (flush),
      .din        (push_if.slave),
      .dout       (out_if.master)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      hdr_cnt_d = hdr_cnt_q;
      done_d    = 1'b0;
      dropped_d = 1'b0;
      push      = 1'b0;
      flush     = 1'b0;
`ifdef MAC_FILTER_EN
      ucast_miss_d = ucast_miss_q;
      bcast_miss_d = bcast_miss_q;
`endif
      unique case (state_q)
         WAIT_IDLE: if (!crsdv) state_d = IDLE;
         IDLE: begin
            if (crsdv) begin
               if (rxd == PREAMBLE_DIBIT) state_d = PREAMBLE;
               else begin
                  state_d   = DROP;
                  dropped_d = 1'b1;
               end
            end
         end
         PREAMBLE: begin
            if (!crsdv) begin
               state_d   = IDLE;
               dropped_d = 1'b1;
            end else if (rxd == SFD_DIBIT) begin
               state_d   = HEADER;
               hdr_cnt_d = '0;
`ifdef MAC_FILTER_EN
               ucast_miss_d = 1'b0;
               bcast_miss_d = 1'b0;
`endif
            end else if (rxd != PREAMBLE_DIBIT) begin
               state_d   = DROP;
               dropped_d = 1'b1;
            end
         end
         HEADER: begin
            if (!crsdv) begin
               state_d   = IDLE;
               dropped_d = 1'b1;
            end else begin
               hdr_cnt_d = hdr_cnt_q + 6'd1;
               if (hdr_cnt_q == HEADER_DIBITS - 6'd1) state_d = PAYLOAD;
`ifdef MAC_FILTER_EN
               if (hdr_cnt_q < MAC_DIBITS) begin
                  ucast_miss_d = ucast_miss_q | (rxd != mac_dibit(MY_MAC, hdr_cnt_q));
                  bcast_miss_d = bcast_miss_q | (rxd != 2'b11);
                  if (hdr_cnt_q == MAC_DIBITS - 6'd1 && ucast_miss_d && bcast_miss_d) begin
                     state_d   = DROP;
                     dropped_d = 1'b1;
                  end
               end
`endif
            end
         end
         PAYLOAD: begin
            if (crsdv) push = 1'b1;
            else begin
               flush   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         DROP: if (!crsdv) state_d = IDLE;
         default: state_d = WAIT_IDLE;
      endcase
   end

   always_ff @(posedge eth_refclk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q       <= WAIT_IDLE;
         hdr_cnt_q     <= '0;
         frame_done    <= 1'b0;
         frame_dropped <= 1'b0;
`ifdef MAC_FILTER_EN
         ucast_miss_q  <= 1'b0;
         bcast_miss_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         hdr_cnt_q     <= hdr_cnt_d;
         frame_done    <= done_d;
         frame_dropped <= dropped_d;
`ifdef MAC_FILTER_EN
         ucast_miss_q  <= ucast_miss_d;
         bcast_miss_q  <= bcast_miss_d;
`endif
      end
   end

endmodule
